// File: rtl/battleship_setup_ctrl.sv
// battleship_setup_ctrl
//
// Runs the ship-placement phase. Player 1 and then player 2 each place exactly
// SHIPS cells on a 28-cell board. A cell is one segment of a 4-digit
// 7-segment display: bit d*7+s is segment s of digit d. A blank handoff screen
// sits between the two players. Once both boards are committed, ready is
// raised. The block also supplies the display mux with the active board and a
// cursor marker.
//
// Parameters
//   SHIPS      cells each player must place (1..28)
//   BLINK_DIV  clk cycles per cursor blink half-period (>= 2)
//
// Ports
//   clk            system clock
//   rst_n          synchronous active-low reset
//   btn_next       pulse: move the cursor to the next cell (27 wraps to 0)
//   btn_sel        pulse: toggle the cell under the cursor
//   btn_done       pulse: commit the board, or acknowledge the handoff screen
//   positions_p1   player 1 board
//   positions_p2   player 2 board
//   disp_positions board shown on the display (blank in HANDOFF and READY)
//   cursor         current cell index, 0..27
//   player         0 = player 1 active, 1 = player 2 active
//   placed         set-bit count of the active board
//   ready          both boards committed
//
// Build option
//   SETUP_BLINK_EN  when defined, the cursor cell blinks with a half-period of
//                   BLINK_DIV cycles. When undefined, no blink counter is
//                   built and the cursor cell is shown permanently inverted.

module battleship_setup_ctrl #(
    parameter int SHIPS     = 5,
    parameter int BLINK_DIV = 15000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_sel,
    input  logic        btn_done,
    output logic [27:0] positions_p1,
    output logic [27:0] positions_p2,
    output logic [27:0] disp_positions,
    output logic [4:0]  cursor,
    output logic        player,
    output logic [4:0]  placed,
    output logic        ready
);

    typedef enum logic [1:0] {
        P1_PLACE = 2'd0,
        HANDOFF  = 2'd1,
        P2_PLACE = 2'd2,
        READY    = 2'd3
    } state_e;

    localparam logic [4:0] SHIPS_C   = 5'(SHIPS);
    localparam logic [4:0] LAST_CELL = 5'd27;

    state_e      state_q, state_d;
    logic [27:0] p1_q, p1_d;
    logic [27:0] p2_q, p2_d;
    logic [27:0] disp_q, disp_d;
    logic [4:0]  cursor_q, cursor_d;
    logic [4:0]  placed_q, placed_d;
    logic        player_q, player_d;
    logic        ready_q, ready_d;

    logic [27:0] cursor_mask;
    logic        cell_set;
    logic        in_place_d;
    logic [27:0] board_d;
    logic        blink_d;

    assign cursor_mask = 28'd1 << cursor_q;
    assign cell_set    = (state_q == P2_PLACE) ? p2_q[cursor_q] : p1_q[cursor_q];

    // Next-state logic. Per cycle, only the highest-priority pulse is acted on:
    // done, then sel, then next. A done that cannot commit still uses up the
    // cycle, so any sel or next arriving with it is dropped.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        cursor_d = cursor_q;
        placed_d = placed_q;
        player_d = player_q;
        ready_d  = ready_q;

        unique case (state_q)
            P1_PLACE, P2_PLACE: begin
                if (btn_done) begin
                    if (placed_q == SHIPS_C) begin
                        if (state_q == P1_PLACE) begin
                            state_d  = HANDOFF;
                            cursor_d = '0;
                            placed_d = '0;
                        end else begin
                            state_d = READY;
                            ready_d = 1'b1;
                        end
                    end
                end else if (btn_sel) begin
                    // A set cell can always be cleared. A clear cell can be set
                    // only while ships remain to be placed.
                    if (cell_set || (placed_q < SHIPS_C)) begin
                        if (state_q == P2_PLACE) p2_d = p2_q ^ cursor_mask;
                        else                     p1_d = p1_q ^ cursor_mask;
                        placed_d = cell_set ? placed_q - 5'd1 : placed_q + 5'd1;
                    end
                end else if (btn_next) begin
                    cursor_d = (cursor_q == LAST_CELL) ? 5'd0 : cursor_q + 5'd1;
                end
            end
            HANDOFF: begin
                if (btn_done) begin
                    state_d  = P2_PLACE;
                    player_d = 1'b1;
                end
            end
            READY: begin
            end
            default: begin
                state_d = P1_PLACE;
            end
        endcase
    end

    // The display is built from next-state values, so it changes on the same
    // edge as the board and cursor it shows.
    assign in_place_d = (state_d == P1_PLACE) || (state_d == P2_PLACE);
    assign board_d    = (state_d == P2_PLACE) ? p2_d : p1_d;

    always_comb begin
        disp_d = '0;
        if (in_place_d) begin
            disp_d = board_d ^ (28'(blink_d) << cursor_d);
        end
    end

`ifdef SETUP_BLINK_EN
    localparam int         CNT_W      = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             blink_q;

    // The blink phase restarts whenever the cursor moves, so the new position
    // is first shown steady (unblinked) for a full half-period.
    always_comb begin
        blink_cnt_d = '0;
        blink_d     = 1'b0;
        if (in_place_d && (cursor_d == cursor_q)) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_d = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                blink_d     = blink_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end
`else
    assign blink_d = 1'b1;
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state_q  <= P1_PLACE;
            p1_q     <= '0;
            p2_q     <= '0;
            disp_q   <= '0;
            cursor_q <= '0;
            placed_q <= '0;
            player_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            disp_q   <= disp_d;
            cursor_q <= cursor_d;
            placed_q <= placed_d;
            player_q <= player_d;
            ready_q  <= ready_d;
        end
    end

    assign positions_p1   = p1_q;
    assign positions_p2   = p2_q;
    assign disp_positions = disp_q;
    assign cursor         = cursor_q;
    assign placed         = placed_q;
    assign player         = player_q;
    assign ready          = ready_q;

endmodule

// File: tb/tb_battleship_setup_ctrl.sv
// Testbench for battleship_setup_ctrl with SHIPS=3 and BLINK_DIV=4. A
// behavioural model predicts every output after each clock. Its predictions
// are queued when the stimulus is applied, then popped and compared once the
// DUT has updated. Directed constant checks cover the key scenarios. Blink
// expectations follow SETUP_BLINK_EN.

module tb_battleship_setup_ctrl;

    localparam int SHIPS     = 3;
    localparam int BLINK_DIV = 4;

    localparam int S_P1 = 0;
    localparam int S_HO = 1;
    localparam int S_P2 = 2;
    localparam int S_RD = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_next = 1'b0;
    logic        btn_sel = 1'b0;
    logic        btn_done = 1'b0;
    logic [27:0] positions_p1;
    logic [27:0] positions_p2;
    logic [27:0] disp_positions;
    logic [4:0]  cursor;
    logic        player;
    logic [4:0]  placed;
    logic        ready;

    battleship_setup_ctrl #(.SHIPS(SHIPS), .BLINK_DIV(BLINK_DIV)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .btn_next       (btn_next),
        .btn_sel        (btn_sel),
        .btn_done       (btn_done),
        .positions_p1   (positions_p1),
        .positions_p2   (positions_p2),
        .disp_positions (disp_positions),
        .cursor         (cursor),
        .player         (player),
        .placed         (placed),
        .ready          (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [27:0] p1;
        logic [27:0] p2;
        logic [27:0] disp;
        logic [4:0]  cursor;
        logic [4:0]  placed;
        logic        player;
        logic        ready;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state
    int          m_st = S_P1;
    logic [27:0] m_p1 = '0;
    logic [27:0] m_p2 = '0;
    logic [4:0]  m_cur = '0;
    logic [4:0]  m_placed = '0;
    logic        m_player = 1'b0;
    logic        m_ready = 1'b0;
    int          m_cnt = 0;
    logic        m_blink = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_step(input bit nx, input bit sl, input bit dn, input bit rs);
        logic [4:0]  old_cur;
        logic [27:0] board;
        logic        in_place;
        exp_t        e;
        old_cur = m_cur;
        if (rs) begin
            m_st = S_P1; m_p1 = '0; m_p2 = '0; m_cur = '0;
            m_placed = '0; m_player = 1'b0; m_ready = 1'b0;
        end else if (m_st == S_P1 || m_st == S_P2) begin
            board = (m_st == S_P2) ? m_p2 : m_p1;
            if (dn) begin
                if (int'(m_placed) == SHIPS) begin
                    if (m_st == S_P1) begin
                        m_st = S_HO; m_cur = '0; m_placed = '0;
                    end else begin
                        m_st = S_RD; m_ready = 1'b1;
                    end
                end
            end else if (sl) begin
                if (board[m_cur]) begin
                    board[m_cur] = 1'b0; m_placed = m_placed - 5'd1;
                end else if (int'(m_placed) < SHIPS) begin
                    board[m_cur] = 1'b1; m_placed = m_placed + 5'd1;
                end
                if (m_st == S_P2) m_p2 = board;
                else              m_p1 = board;
            end else if (nx) begin
                m_cur = (m_cur == 5'd27) ? 5'd0 : m_cur + 5'd1;
            end
        end else if (m_st == S_HO) begin
            if (dn) begin
                m_st = S_P2; m_player = 1'b1;
            end
        end
        in_place = (m_st == S_P1 || m_st == S_P2);
`ifdef SETUP_BLINK_EN
        if (rs || !in_place || m_cur != old_cur) begin
            m_cnt = 0; m_blink = 1'b0;
        end else if (m_cnt == BLINK_DIV - 1) begin
            m_cnt = 0; m_blink = ~m_blink;
        end else begin
            m_cnt++;
        end
`else
        m_blink = 1'b1;
`endif
        board  = (m_st == S_P2) ? m_p2 : m_p1;
        e.p1     = m_p1;
        e.p2     = m_p2;
        e.disp   = (!rs && in_place) ? (board ^ (28'(m_blink) << m_cur)) : 28'd0;
        e.cursor = m_cur;
        e.placed = m_placed;
        e.player = m_player;
        e.ready  = m_ready;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("sb_p1",     positions_p1,   e.p1);
            check("sb_p2",     positions_p2,   e.p2);
            check("sb_disp",   disp_positions, e.disp);
            check("sb_cursor", cursor,         e.cursor);
            check("sb_placed", placed,         e.placed);
            check("sb_player", player,         e.player);
            check("sb_ready",  ready,          e.ready);
        end
    endtask

    // One clock: apply pulses, predict, clock, then compare just after the edge.
    task automatic step(input bit nx = 0, input bit sl = 0, input bit dn = 0, input bit rs = 0);
        @(negedge clk);
        btn_next = nx;
        btn_sel  = sl;
        btn_done = dn;
        rst_n    = ~rs;
        model_step(nx, sl, dn, rs);
        @(posedge clk);
        #1;
        btn_next = 1'b0;
        btn_sel  = 1'b0;
        btn_done = 1'b0;
        rst_n    = 1'b1;
        compare_out();
    endtask

    logic exp_bit;

    initial begin
        // Reset
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("rst_p1", positions_p1, 28'h0);
        check("rst_p2", positions_p2, 28'h0);
        check("rst_disp", disp_positions, 28'h0);
        check("rst_cursor", cursor, 5'd0);
        check("rst_placed", placed, 5'd0);
        check("rst_player", player, 1'b0);
        check("rst_ready", ready, 1'b0);

        // Cursor walk with wrap
        for (int i = 0; i < 28; i++) step(1, 0, 0);
        check("walk_cursor", cursor, 5'd0);
        check("walk_p1", positions_p1, 28'h0);

        // Place cells 0, 1 and 2
        step(0, 1, 0); step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 1, 0);
        check("p1_three", positions_p1, 28'h0000007);
        check("p1_placed3", placed, 5'd3);

        // Fourth select at cell 3 is ignored at the limit
        step(1, 0, 0); step(0, 1, 0);
        check("p1_full_ignore", positions_p1, 28'h0000007);
        check("p1_full_placed", placed, 5'd3);

        // Wrap back to cell 1 and clear it
        for (int i = 0; i < 26; i++) step(1, 0, 0);
        check("cursor_at1", cursor, 5'd1);
        step(0, 1, 0);
        check("p1_clear1", positions_p1, 28'h0000005);
        check("p1_placed2", placed, 5'd2);

        // Done with too few ships
        step(0, 0, 1);
        check("early_done_player", player, 1'b0);
        check("early_done_cursor", cursor, 5'd1);
        check("early_done_p1", positions_p1, 28'h0000005);

        // Same-cycle sel + next: sel wins and the cursor stays
        step(1, 1, 0);
        check("selnext_p1", positions_p1, 28'h0000007);
        check("selnext_cursor", cursor, 5'd1);

        // Commit player 1 and enter HANDOFF
        step(0, 0, 1);
        check("ho_disp", disp_positions, 28'h0);
        check("ho_cursor", cursor, 5'd0);
        check("ho_placed", placed, 5'd0);
        step(0, 1, 0);
        step(1, 0, 0);
        check("ho_sel_ignore_p2", positions_p2, 28'h0);
        check("ho_next_ignore", cursor, 5'd0);
        step(0, 0, 1);
        check("p2_player", player, 1'b1);

        // Player 2 places cells 0, 1 and 2
        step(0, 1, 0); step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 1, 0);
        check("p2_three", positions_p2, 28'h0000007);

        // Done and sel together: done wins and the select is dropped
        step(0, 1, 1);
        check("rdy_ready", ready, 1'b1);
        check("rdy_p2", positions_p2, 28'h0000007);
        check("rdy_disp", disp_positions, 28'h0);
        check("rdy_p1_frozen", positions_p1, 28'h0000007);
        step(1, 1, 1);
        check("rdy_hold_cursor", cursor, 5'd2);
        check("rdy_hold_p2", positions_p2, 28'h0000007);

        // Blink at cursor 5 on an empty board
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        for (int k = 0; k < 12; k++) begin
            if (k > 0) step(0, 0, 0);
`ifdef SETUP_BLINK_EN
            exp_bit = ((k / BLINK_DIV) % 2) == 1;
`else
            exp_bit = 1'b1;
`endif
            check("blink_c5", disp_positions[5], exp_bit);
        end
        step(1, 0, 0);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step(0, 0, 0);
`ifdef SETUP_BLINK_EN
            exp_bit = 1'b0;
`else
            exp_bit = 1'b1;
`endif
            check("blink_c6_restart", disp_positions[6], exp_bit);
            check("blink_c6_old_off", disp_positions[5], 1'b0);
        end

        // Reset in the middle of P2_PLACE, with buttons pulsed in the same cycle
        step(0, 0, 0, 1);
        step(0, 1, 0); step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 1, 0);
        step(0, 0, 1); step(0, 0, 1);
        step(0, 1, 0);
        check("midp2_placed", placed, 5'd1);
        step(1, 1, 1, 1);
        check("midrst_p1", positions_p1, 28'h0);
        check("midrst_p2", positions_p2, 28'h0);
        check("midrst_disp", disp_positions, 28'h0);
        check("midrst_cursor", cursor, 5'd0);
        check("midrst_placed", placed, 5'd0);
        check("midrst_player", player, 1'b0);
        check("midrst_ready", ready, 1'b0);
        step(1, 0, 0);
        check("postrst_cursor", cursor, 5'd1);
        step(0, 1, 0);
        check("postrst_p1", positions_p1, 28'h0000002);

        check("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/battleship_setup_ctrl.md
# battleship_setup_ctrl

Sequencer for the ship-placement phase of the game. It owns both players' 28-bit placement boards: 4 digits × 7 segments, bit `d*7+s` is segment `s` of digit `d`. It walks a cursor over the 28 cells, lets each player place exactly `SHIPS` cells, hands off from player 1 to player 2, then signals ready. It also drives the shared 4-digit display mux with the active board plus a blinking cursor.

## Interface
Parameters:
- `SHIPS`, default 5: cells each player must place, range 1..28.
- `BLINK_DIV`, default 15000: clk cycles per cursor blink half-period, ≥ 2.

Ports:
- `clk`  in  1: system clock.
- `rst_n`  in  1: synchronous, active-low reset.
- `btn_next`  in  1: single-cycle, pre-debounced pulse; advances the cursor.
- `btn_sel`  in  1: single-cycle pulse; toggles the cell under the cursor.
- `btn_done`  in  1: single-cycle pulse; commits the board or acknowledges the handoff.
- `positions_p1`  out  28: player 1 committed/working board.
- `positions_p2`  out  28: player 2 committed/working board.
- `disp_positions`  out  28: board to feed the display driver.
- `cursor`  out  5: current cell index, 0..27.
- `player`  out  1: 0 = player 1 active, 1 = player 2 active.
- `placed`  out  5: set-bit count of the active board.
- `ready`  out  1: both boards committed.

## Operation
- State register with four states:
  - `P1_PLACE`
  - `HANDOFF`
  - `P2_PLACE`
  - `READY`
- Reset values:
  - state `P1_PLACE`.
  - `positions_p1`, `positions_p2`, `cursor`, `placed`, `player` all 0.
  - `ready` = 0.
  - Blink counter and blink phase 0.
- In either PLACE state, the active board is p1 or p2 according to state:
  - `btn_next`: `cursor` ← `cursor`+1; 27 wraps to 0.
  - `btn_sel`, cell clear and `placed` < `SHIPS`: set the bit, `placed`+1.
  - `btn_sel`, cell clear and `placed` == `SHIPS`: ignored; board and count unchanged.
  - `btn_sel`, cell set: clear the bit, `placed`−1.
  - `btn_done` with `placed` == `SHIPS`: leave the state. `P1_PLACE` goes to `HANDOFF`; `P2_PLACE` goes to `READY`.
  - `btn_done` with `placed` ≠ `SHIPS`: ignored.
- Simultaneous pulses: only one action per cycle, priority `btn_done` > `btn_sel` > `btn_next`. Lower-priority pulses in that cycle are dropped.
- On leaving `P1_PLACE`:
  - `cursor` ← 0, `placed` ← 0.
  - `positions_p1` is frozen.
- `HANDOFF`:
  - `disp_positions` = 0 (blank, so player 2 cannot see player 1's board).
  - `btn_sel` and `btn_next` are ignored.
  - `btn_done` moves to `P2_PLACE` and sets `player` = 1.
- `READY`:
  - `ready` = 1; all buttons ignored.
  - `disp_positions` = 0.
  - Boards hold until `rst_n`.
- Display while in a PLACE state: `disp_positions` = active board XOR (`blink` << `cursor`).
- Boards are only ever written through the toggle path. `placed` always equals popcount of the active board.

## Timing
- All outputs are registered. An action taken on a pulse at edge N is visible after edge N.
- `disp_positions` is registered from next-state values, so it updates in the same cycle as the board and cursor.
- Blink counter:
  - Counts 0..`BLINK_DIV`−1. At terminal count it wraps and toggles `blink`.
  - Free-running in the PLACE states.
  - Held at 0 with `blink` = 0 outside them.
  - Reset to 0 with `blink` = 0 on every `cursor` change, so the new position appears steady first.
- `rst_n` low at any edge, including mid-placement or in `HANDOFF`, returns everything to the reset values on that edge. Button pulses in that cycle are ignored.

## Configuration
- `SETUP_BLINK_EN` defined:
  - Blink counter and blink phase are implemented as above.
- `SETUP_BLINK_EN` undefined:
  - No counter is synthesized; `blink` is constant 1.
  - The cursor cell is shown permanently inverted in the PLACE states.
  - All other behaviour is identical.

## Test plan
Bench parameters: `SHIPS`=3, `BLINK_DIV`=4.
- Reset, then 28 `btn_next` pulses → `cursor` walks 0..27 and returns to 0; boards stay 0.
- In `P1_PLACE`, `btn_sel` at cursors 0, 1, 2, then next to 3 and `btn_sel`:
  - After the three selects: `positions_p1` = 28'h0000007, `placed` = 3.
  - Fourth select ignored, `placed` stays 3.
  - `btn_sel` back on cell 1 → 28'h0000005, `placed` = 2.
- `btn_done` with `placed` = 2 → stays in `P1_PLACE`.
- Place a third cell, then `btn_done`:
  - → `HANDOFF`, `disp_positions` = 0, `cursor` = 0.
  - `btn_sel` in `HANDOFF` ignored.
  - `btn_done` → `player` = 1.
- Same-cycle `btn_done` + `btn_sel` with `placed` = 3 in `P2_PLACE`:
  - → `READY`, `ready` = 1, `positions_p2` unchanged by the select.
- Blink with `SETUP_BLINK_EN` defined, cursor 5, empty board:
  - `disp_positions` bit 5 toggles every 4 cycles.
  - A `btn_next` restarts the phase with bit 6 at 0 for 4 cycles.
- `rst_n` low mid-`P2_PLACE` → next edge all outputs 0, state `P1_PLACE`.
